// File: rtl/cpu_bus_pkg.sv
// Shared SRAM-port definitions for the core's instruction/data buses.
// Bus widths, default window bases and the byte-lane write merge.
package cpu_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_WE_W   = 4;

  localparam logic [BUS_ADDR_W-1:0] IMEM_BASE = 32'h1C00_0000;
  localparam logic [BUS_ADDR_W-1:0] DMEM_BASE = 32'h1C01_0000;

  typedef logic [BUS_DATA_W-1:0] word_t;

  function automatic word_t byte_merge(input word_t                old_word,
                                       input word_t                wdata,
                                       input logic [BUS_WE_W-1:0]  we);
    word_t res;
    res = old_word;
    for (int i = 0; i < BUS_WE_W; i++) begin
      if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// LATENCY-deep {valid, data} shift register; no backpressure, one entry per cycle.
// Data stages only load behind a valid entry, so the output holds the last response.
module sram_rd_pipe
  import cpu_bus_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_vld,
  input  word_t in_dat,
  output logic  out_vld,
  output word_t out_dat
);

  logic  [LATENCY-1:0]        vld_q, vld_d;
  word_t [LATENCY-1:0]        dat_q, dat_d;
  word_t [LATENCY-1:0]        shf_dat;

  always_comb begin
    vld_d      = vld_q << 1;
    vld_d[0]   = in_vld;
    shf_dat    = dat_q << BUS_DATA_W;
    shf_dat[0] = in_dat;
    dat_d      = dat_q;
    for (int i = 0; i < LATENCY; i++) begin
      if (vld_d[i]) dat_d[i] = shf_dat[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/sram_responder.sv
// SRAM-port responder: word array with byte-lane writes, LATENCY-cycle read pipe,
// access counters and a sticky out-of-window flag. No backpressure on responses.
module sram_responder
  import cpu_bus_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter logic [31:0] BASE    = IMEM_BASE,
  parameter int          LATENCY = 1,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             oor,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("sram_responder: LATENCY must be in 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("sram_responder: ADDR_W must be in 1..29");
  end

  word_t mem [0:(1<<ADDR_W)-1];

  logic [29:0]       woff;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              wr_fire;
  logic              rd_fire;
  word_t             rd_word;
  logic              unused_addr_lsb;

  // Work in word units; the wrapping subtract also rejects addresses below BASE.
  assign woff            = addr[31:2] - BASE[31:2];
  assign in_range        = (woff[29:ADDR_W] == '0);
  assign word_idx        = woff[ADDR_W-1:0];
  assign unused_addr_lsb = ^addr[1:0];

  assign wr_fire = en && (we != '0) && in_range && !reset;
  assign rd_fire = en && (we == '0);
  assign rd_word = in_range ? mem[word_idx] : '0;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[word_idx] <= byte_merge(mem[word_idx], wdata, we);
  end

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             oor_q, oor_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    oor_d    = oor_q;
    if (en) begin
      if (we == '0)    rd_cnt_d = rd_cnt_q + CNT_W'(1);
      else if (in_range) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (!in_range)   oor_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      oor_q    <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      oor_q    <= oor_d;
    end
  end

  sram_rd_pipe #(
    .LATENCY (LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_fire),
    .in_dat  (rd_word),
    .out_vld (rvalid),
    .out_dat (rdata)
  );

  assign oor    = oor_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (LATENCY 1, 2, 3) share one stimulus stream;
// read responses are checked against a per-instance queue of {data, due cycle}.
module tb_sram_responder;

  localparam int          AW     = 6;
  localparam int          NWORDS = 1 << AW;
  localparam logic [31:0] BASE   = 32'h1C00_0000;
  localparam int          NDUT   = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic [3:0]  we    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0]     rdata  [NDUT];
  logic [NDUT-1:0] rvalid;
  logic [NDUT-1:0] oor;
  logic [31:0]     rd_cnt [NDUT];
  logic [31:0]     wr_cnt [NDUT];

  sram_responder #(.ADDR_W(AW), .BASE(BASE), .LATENCY(1), .CNT_W(32)) u_l1 (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .oor(oor[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));
  sram_responder #(.ADDR_W(AW), .BASE(BASE), .LATENCY(2), .CNT_W(32)) u_l2 (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .oor(oor[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));
  sram_responder #(.ADDR_W(AW), .BASE(BASE), .LATENCY(3), .CNT_W(32)) u_l3 (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata[2]), .rvalid(rvalid[2]), .oor(oor[2]), .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2]));

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  exp_t sb [NDUT][$];
  int   cyc_n   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_exp  = 0;
  int   wr_exp  = 0;
  bit   oor_exp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, idx, act, exp, cyc_n);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * NWORDS);
  endfunction

  // Response checker: every rvalid must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      while (sb[k].size() > 0 && sb[k][0].due < cyc_n) begin
        e = sb[k].pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL resp_missing dut%0d: got no rvalid expected data %h at cycle %0d", k, e.dat, e.due);
      end
      if (rvalid[k]) begin
        if (sb[k].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected dut%0d: got rvalid with %h expected none (cycle %0d)", k, rdata[k], cyc_n);
        end else begin
          e = sb[k].pop_front();
          chk("resp_cycle", k, 32'(cyc_n), 32'(e.due));
          chk("resp_data", k, rdata[k], e.dat);
        end
      end
    end
  end

  // Drive one request for one cycle; called at a negedge, returns at the next negedge.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] x);
    exp_t ent;
    en = e; we = w; addr = a; wdata = d;
    if (e) begin
      if (w == 4'h0) begin
        rd_exp++;
        for (int k = 0; k < NDUT; k++) begin
          ent.dat = x;
          ent.due = cyc_n + k + 1;
          sb[k].push_back(ent);
        end
      end else if (in_win(a)) begin
        wr_exp++;
      end
      if (!in_win(a)) oor_exp = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_quiet(input logic [31:0] exp_rdata, input bit exp_oor);
    for (int k = 0; k < NDUT; k++) begin
      chk("rvalid_idle", k, {31'h0, rvalid[k]}, 32'h0);
      chk("rdata_hold", k, rdata[k], exp_rdata);
      chk("oor", k, {31'h0, oor[k]}, {31'h0, exp_oor});
      chk("rd_cnt", k, rd_cnt[k], 32'(rd_exp));
      chk("wr_cnt", k, wr_cnt[k], 32'(wr_exp));
    end
  endtask

  vec_t tbl [19];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, BASE + 32'h00, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b1, 4'hF, BASE + 32'h04, 32'h1111_1111, 32'h0};
    tbl[2]  = '{1'b1, 4'h0, BASE + 32'h00, 32'h0,         32'h1234_5678};
    tbl[3]  = '{1'b1, 4'h5, BASE + 32'h04, 32'hAABB_CCDD, 32'h0};
    tbl[4]  = '{1'b1, 4'h0, BASE + 32'h06, 32'h0,         32'h11BB_11DD};
    tbl[5]  = '{1'b1, 4'hF, BASE + 32'h10, 32'h0000_0001, 32'h0};
    tbl[6]  = '{1'b1, 4'hF, BASE + 32'h14, 32'h0000_0002, 32'h0};
    tbl[7]  = '{1'b1, 4'hF, BASE + 32'h18, 32'h0000_0003, 32'h0};
    tbl[8]  = '{1'b1, 4'h0, BASE + 32'h10, 32'h0,         32'h0000_0001};
    tbl[9]  = '{1'b1, 4'h0, BASE + 32'h14, 32'h0,         32'h0000_0002};
    tbl[10] = '{1'b1, 4'h0, BASE + 32'h18, 32'h0,         32'h0000_0003};
    tbl[11] = '{1'b1, 4'hF, BASE + 32'h18, 32'hDEAD_BEEF, 32'h0};
    tbl[12] = '{1'b1, 4'h0, BASE + 32'h18, 32'h0,         32'hDEAD_BEEF};
    tbl[13] = '{1'b0, 4'hF, BASE + 32'h00, 32'hFFFF_FFFF, 32'h0};
    tbl[14] = '{1'b1, 4'h0, BASE + 32'h00, 32'h0,         32'h1234_5678};
    tbl[15] = '{1'b1, 4'hF, BASE + 32'hFC, 32'hCAFE_F00D, 32'h0};
    tbl[16] = '{1'b1, 4'h0, BASE + 32'hFC, 32'h0,         32'hCAFE_F00D};
    tbl[17] = '{1'b1, 4'h8, BASE + 32'hFC, 32'h5A00_0000, 32'h0};
    tbl[18] = '{1'b1, 4'h0, BASE + 32'hFC, 32'h0,         32'h5AFE_F00D};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_quiet(32'h0, 1'b0);

    // Back-to-back table traffic, including the 1/2/3 burst and read-after-write.
    for (int i = 0; i < 19; i++) step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
    idle(5);
    chk_quiet(32'h5AFE_F00D, 1'b0);

    // Single read: response next cycle on the LATENCY=1 instance, then held while idle.
    step(1'b1, 4'h0, BASE, 32'h0, 32'h1234_5678);
    chk("l1_rvalid", 0, {31'h0, rvalid[0]}, 32'h1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    chk("l1_rvalid_next", 0, {31'h0, rvalid[0]}, 32'h0);
    chk("l1_rdata_next", 0, rdata[0], 32'h1234_5678);
    idle(4);
    chk_quiet(32'h1234_5678, 1'b0);

    // Outside the window on both sides: writes dropped, reads return zero, flag sticks.
    step(1'b1, 4'hF, BASE - 32'h4, 32'h5555_5555, 32'h0);
    step(1'b1, 4'h0, BASE - 32'h4, 32'h0, 32'h0);
    idle(4);
    chk_quiet(32'h0, 1'b1);
    step(1'b1, 4'hF, BASE + 32'(4 * NWORDS), 32'h6666_6666, 32'h0);
    step(1'b1, 4'h0, BASE + 32'(4 * NWORDS), 32'h0, 32'h0);
    step(1'b1, 4'h0, BASE, 32'h0, 32'h1234_5678);
    idle(5);
    chk_quiet(32'h1234_5678, 1'b1);

    // Reset one cycle after a read: deeper pipes must never answer it; write under reset is lost.
    step(1'b1, 4'h0, BASE + 32'h4, 32'h0, 32'h11BB_11DD);
    reset = 1'b1;
    en = 1'b1; we = 4'hF; addr = BASE; wdata = 32'h0;
    for (int k = 0; k < NDUT; k++) begin
      while (sb[k].size() > 0 && sb[k][$].due > cyc_n) void'(sb[k].pop_back());
    end
    @(negedge clk);
    en = 1'b0; we = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    rd_exp = 0; wr_exp = 0; oor_exp = 1'b0;
    chk_quiet(32'h0, 1'b0);
    idle(4);
    chk_quiet(32'h0, 1'b0);
    step(1'b1, 4'h0, BASE, 32'h0, 32'h1234_5678);
    idle(5);
    chk_quiet(32'h1234_5678, 1'b0);

    for (int k = 0; k < NDUT; k++) chk("pending", k, 32'(sb[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
